// File: rtl/mux_n_arb.sv
// mux_n_arb: N-channel valid/ready mux (explicit select or round-robin grant)
// feeding a one-entry registered output stage with backpressure and flush.
module mux_n_arb #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      flush,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Distance of channel ch from the round-robin pointer, walking upwards with wrap.
    function automatic logic [SEL_W:0] rr_dist(input logic [SEL_W-1:0] ch,
                                               input logic [SEL_W-1:0] p);
        if (ch >= p) begin
            return {1'b0, ch} - {1'b0, p};
        end
        return {1'b0, ch} + (SEL_W+1)'(CHANNELS) - {1'b0, p};
    endfunction

    function automatic logic [SEL_W-1:0] ptr_next(input logic [SEL_W-1:0] g);
        return (g == SEL_W'(CHANNELS - 1)) ? '0 : g + 1'b1;
    endfunction

    logic [WIDTH-1:0] r_data_p1;
    logic [SEL_W-1:0] r_chan_p1;
    logic             r_vld_p1;
    logic [SEL_W-1:0] r_ptr;

    logic [SEL_W-1:0] w_grant;
    logic [SEL_W:0]   w_best;
    logic             w_gnt_vld;
    logic             w_can_accept;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;

    // Stage 0: grant selection and input handshake
    always_comb begin
        w_gnt_vld = 1'b0;
        w_grant   = '0;
        w_best    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (MODE == 0) begin
                if (in_valid[i] && (sel == SEL_W'(i))) begin
                    w_gnt_vld = 1'b1;
                    w_grant   = SEL_W'(i);
                end
            end else if (in_valid[i] &&
                         (!w_gnt_vld || (rr_dist(SEL_W'(i), r_ptr) < w_best))) begin
                w_gnt_vld = 1'b1;
                w_grant   = SEL_W'(i);
                w_best    = rr_dist(SEL_W'(i), r_ptr);
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // rst gates acceptance so in_ready stays low while reset is held
    assign w_can_accept = !rst && !flush && (!r_vld_p1 || out_ready);
    assign w_xfer       = w_can_accept && w_gnt_vld;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = w_xfer && (w_grant == SEL_W'(i));
        end
    end

    // Stage 1: registered output entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_p1 <= '0;
            r_chan_p1 <= '0;
            r_vld_p1  <= 1'b0;
            r_ptr     <= '0;
        end else begin
            if (flush) begin
                r_vld_p1 <= 1'b0;
            end else if (w_xfer) begin
                r_vld_p1  <= 1'b1;
                r_data_p1 <= w_sel_data;
                r_chan_p1 <= w_grant;
            end else if (out_ready) begin
                r_vld_p1 <= 1'b0;
            end
            if ((MODE == 1) && w_xfer) begin
                r_ptr <= ptr_next(w_grant);
            end
        end
    end

    assign out_data  = r_data_p1;
    assign out_chan  = r_chan_p1;
    assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_mux_n_arb.sv
// Self-checking bench for mux_n_arb: explicit select (4 and 3 channels) and round-robin.
// Expected outputs are queued at stimulus time and compared as the consumer takes them.
module tb_mux_n_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // explicit select, 4 channels
    logic [127:0] s4_data;
    logic [3:0]   s4_valid, s4_ready;
    logic [1:0]   s4_sel, s4_ochan;
    logic         s4_flush, s4_ovalid, s4_oready;
    logic [31:0]  s4_odata;
    // round-robin, 4 channels
    logic [127:0] r4_data;
    logic [3:0]   r4_valid, r4_ready;
    logic [1:0]   r4_sel, r4_ochan;
    logic         r4_flush, r4_ovalid, r4_oready;
    logic [31:0]  r4_odata;
    // explicit select, 3 channels
    logic [95:0]  s3_data;
    logic [2:0]   s3_valid, s3_ready;
    logic [1:0]   s3_sel, s3_ochan;
    logic         s3_flush, s3_ovalid, s3_oready;
    logic [31:0]  s3_odata;

    logic [33:0] sb_s4[$];
    logic [33:0] sb_r4[$];
    logic [33:0] sb_s3[$];

    mux_n_arb #(.WIDTH(32), .CHANNELS(4), .MODE(0)) u_sel4 (
        .clk(clk), .rst(rst), .in_data(s4_data), .in_valid(s4_valid), .in_ready(s4_ready),
        .sel(s4_sel), .flush(s4_flush), .out_data(s4_odata), .out_chan(s4_ochan),
        .out_valid(s4_ovalid), .out_ready(s4_oready));

    mux_n_arb #(.WIDTH(32), .CHANNELS(4), .MODE(1)) u_rr4 (
        .clk(clk), .rst(rst), .in_data(r4_data), .in_valid(r4_valid), .in_ready(r4_ready),
        .sel(r4_sel), .flush(r4_flush), .out_data(r4_odata), .out_chan(r4_ochan),
        .out_valid(r4_ovalid), .out_ready(r4_oready));

    mux_n_arb #(.WIDTH(32), .CHANNELS(3), .MODE(0)) u_sel3 (
        .clk(clk), .rst(rst), .in_data(s3_data), .in_valid(s3_valid), .in_ready(s3_ready),
        .sel(s3_sel), .flush(s3_flush), .out_data(s3_odata), .out_chan(s3_ochan),
        .out_valid(s3_ovalid), .out_ready(s3_oready));

    // Consumers: an entry leaves on out_valid&out_ready, or is dropped by flush.
    always @(negedge clk) begin : mon_s4
        logic [33:0] e;
        if (s4_ovalid && (s4_oready || s4_flush)) begin
            if (sb_s4.size() == 0) begin
                check_eq("s4_unexpected", {s4_ochan, s4_odata}, 34'h0);
            end else begin
                e = sb_s4.pop_front();
                if (!s4_flush) check_eq("s4_out", {s4_ochan, s4_odata}, e);
            end
        end
    end

    always @(negedge clk) begin : mon_r4
        logic [33:0] e;
        if (r4_ovalid && (r4_oready || r4_flush)) begin
            if (sb_r4.size() == 0) begin
                check_eq("r4_unexpected", {r4_ochan, r4_odata}, 34'h0);
            end else begin
                e = sb_r4.pop_front();
                if (!r4_flush) check_eq("r4_out", {r4_ochan, r4_odata}, e);
            end
        end
    end

    always @(negedge clk) begin : mon_s3
        logic [33:0] e;
        if (s3_ovalid && (s3_oready || s3_flush)) begin
            if (sb_s3.size() == 0) begin
                check_eq("s3_unexpected", {s3_ochan, s3_odata}, 34'h0);
            end else begin
                e = sb_s3.pop_front();
                if (!s3_flush) check_eq("s3_out", {s3_ochan, s3_odata}, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        s4_data = '0; s4_valid = '0; s4_sel = '0; s4_flush = 1'b0; s4_oready = 1'b1;
        r4_data = '0; r4_valid = '0; r4_sel = '0; r4_flush = 1'b0; r4_oready = 1'b1;
        s3_data = '0; s3_valid = '0; s3_sel = '0; s3_flush = 1'b0; s3_oready = 1'b1;

        // reset state, with a valid request pending
        s4_sel = 2'd2;
        s4_data[2*32 +: 32] = 32'hDEADBEEF;
        s4_valid = 4'b0100;
        #1;
        check_eq("rst_out_valid", s4_ovalid, 1'b0);
        check_eq("rst_out_data", s4_odata, 32'h0);
        check_eq("rst_out_chan", s4_ochan, 2'd0);
        check_eq("rst_in_ready", s4_ready, 4'b0000);
        check_eq("rst_rr_in_ready", r4_ready, 4'b0000);

        // pass-through
        step();
        rst = 1'b0;
        #1;
        check_eq("pt_in_ready", s4_ready, 4'b0100);
        sb_s4.push_back({2'd2, 32'hDEADBEEF});
        step();
        s4_valid = 4'b0000;
        #1;
        check_eq("pt_out_valid", s4_ovalid, 1'b1);
        check_eq("pt_out_data", s4_odata, 32'hDEADBEEF);
        check_eq("pt_out_chan", s4_ochan, 2'd2);
        step();
        check_eq("pt_drained", s4_ovalid, 1'b0);
        check_eq("pt_data_kept", s4_odata, 32'hDEADBEEF);

        // asynchronous reset drops a held entry immediately
        s4_data[2*32 +: 32] = 32'hCAFEF00D;
        s4_valid = 4'b0100;
        #1;
        sb_s4.push_back({2'd2, 32'hCAFEF00D});
        step();
        s4_valid = 4'b0000;
        s4_oready = 1'b0;
        #1;
        check_eq("ar_loaded", s4_ovalid, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("ar_out_valid", s4_ovalid, 1'b0);
        check_eq("ar_out_data", s4_odata, 32'h0);
        sb_s4.delete();
        step();
        rst = 1'b0;
        s4_oready = 1'b1;

        // backpressure
        s4_sel = 2'd0;
        s4_data[0 +: 32] = 32'h11;
        s4_valid = 4'b0001;
        #1;
        check_eq("bp_fill_ready", s4_ready, 4'b0001);
        sb_s4.push_back({2'd0, 32'h11});
        step();
        s4_sel = 2'd1;
        s4_data[32 +: 32] = 32'h22;
        s4_valid = 4'b0010;
        s4_oready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("bp_hold_ready", s4_ready, 4'b0000);
            check_eq("bp_hold_data", s4_odata, 32'h11);
            check_eq("bp_hold_valid", s4_ovalid, 1'b1);
            step();
        end
        s4_oready = 1'b1;
        #1;
        check_eq("bp_release_ready", s4_ready, 4'b0010);
        sb_s4.push_back({2'd1, 32'h22});
        step();
        s4_valid = 4'b0000;
        #1;
        check_eq("bp_refill_valid", s4_ovalid, 1'b1);
        check_eq("bp_refill_data", s4_odata, 32'h22);
        check_eq("bp_refill_chan", s4_ochan, 2'd1);
        step();
        check_eq("bp_drain_valid", s4_ovalid, 1'b0);
        check_eq("bp_drain_chan", s4_ochan, 2'd1);

        // flush
        s4_sel = 2'd0;
        s4_data[0 +: 32] = 32'h55;
        s4_valid = 4'b0001;
        #1;
        sb_s4.push_back({2'd0, 32'h55});
        step();
        s4_data[0 +: 32] = 32'h66;
        s4_flush = 1'b1;
        #1;
        check_eq("fl_held_data", s4_odata, 32'h55);
        check_eq("fl_in_ready", s4_ready, 4'b0000);
        step();
        s4_flush = 1'b0;
        #1;
        check_eq("fl_out_valid", s4_ovalid, 1'b0);
        check_eq("fl_accept_after", s4_ready, 4'b0001);
        sb_s4.push_back({2'd0, 32'h66});
        step();
        s4_valid = 4'b0000;
        #1;
        check_eq("fl_new_data", s4_odata, 32'h66);
        step();
        step();

        // round-robin fairness: all channels valid
        for (int i = 0; i < 4; i++) r4_data[i*32 +: 32] = 32'hA0 + i;
        r4_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_eq("rr_fair_ready", r4_ready, 4'b0001 << (k % 4));
            sb_r4.push_back({2'(k % 4), 32'hA0 + 32'(k % 4)});
            step();
        end
        // pointer is 2; a lone ch0 request wraps to it and leaves pointer at 1
        r4_valid = 4'b0001;
        #1;
        check_eq("rr_wrap_ready", r4_ready, 4'b0001);
        sb_r4.push_back({2'd0, 32'hA0});
        step();
        // skip: pointer 1 with ch0/ch3 valid grants ch3, then ch0, then ch3
        r4_valid = 4'b1001;
        #1;
        check_eq("rr_skip_ch3", r4_ready, 4'b1000);
        sb_r4.push_back({2'd3, 32'hA3});
        step();
        #1;
        check_eq("rr_skip_ch0", r4_ready, 4'b0001);
        sb_r4.push_back({2'd0, 32'hA0});
        step();
        #1;
        check_eq("rr_skip_again", r4_ready, 4'b1000);
        sb_r4.push_back({2'd3, 32'hA3});
        step();
        r4_valid = 4'b0000;
        #1;
        check_eq("rr_last_chan", r4_ochan, 2'd3);
        step();
        step();

        // out-of-range select on 3 channels never grants
        for (int i = 0; i < 3; i++) s3_data[i*32 +: 32] = 32'hC0 + i;
        s3_sel = 2'd3;
        s3_valid = 3'b111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("oor_in_ready", s3_ready, 3'b000);
            check_eq("oor_out_valid", s3_ovalid, 1'b0);
            step();
        end
        s3_sel = 2'd2;
        #1;
        check_eq("s3_ch2_ready", s3_ready, 3'b100);
        sb_s3.push_back({2'd2, 32'hC2});
        step();
        s3_valid = 3'b000;
        #1;
        check_eq("s3_ch2_valid", s3_ovalid, 1'b1);
        step();
        step();

        check_eq("sb_s4_empty", 64'(sb_s4.size()), 64'd0);
        check_eq("sb_r4_empty", 64'(sb_r4.size()), 64'd0);
        check_eq("sb_s3_empty", 64'(sb_s3.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
